// File: rtl/key_move_scheduler.sv
// key_move_scheduler
//   Front end between the four raw direction buttons and the 2048 engine.
//   Each key is synchronized, debounced and turned into a sticky request.
//   Requests are arbitrated round-robin and handed out one move at a time
//   over valid/ready. A programmable cool-down follows every accepted move.
//
//   Optional feature: define KEY_REPEAT_EN to build per-key auto-repeat
//   timers (REPEAT_DELAY / REPEAT_RATE). Without it those parameters are
//   unused and no timers exist.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   key_n[3:0]  raw buttons, active-low (0 up, 1 down, 2 left, 3 right)
//   accept_en   1 = presses accepted; 0 = pending cleared, presses ignored
//   move_ready  engine can take a move this cycle
//   move_valid  move offered (registered)
//   move_dir    direction of the offered move (registered)
//   pending     sticky request bits

// Per-key front end: synchronizer, debouncer, press detector and the
// optional auto-repeat timer. req is a one-cycle request pulse.
module key_debounce #(
   parameter int DEBOUNCE_LEN = 16
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_DELAY = 1000,
   parameter int REPEAT_RATE  = 250
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw_n,
   input  logic accept_en,
   output logic req
);
   localparam int CW = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;
   logic          press;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= ~key_raw_n;
         sync2   <= sync1;
         level_d <= level;
         // Any sample that agrees with the current level restarts the count,
         // so only an uninterrupted run of DEBOUNCE_LEN samples flips it.
         if (sync2 != level) begin
            if (cnt == CW'(DEBOUNCE_LEN - 1)) begin
               level <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   // Registered rising edge of the debounced level: lands in pending one
   // edge after the debounced level itself rises.
   assign press = level & ~level_d;

`ifdef KEY_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   // rpt_cnt holds the number of edges since the last press or repeat, so
   // the first repeat lands REPEAT_DELAY edges after the press edge.
   logic [RW-1:0] rpt_cnt;
   logic          rpt_first;
   logic          rpt_fire;

   assign rpt_fire = level && accept_en && !press &&
                     (rpt_cnt == (rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else if (!level || !accept_en) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else if (press) begin
         rpt_cnt   <= RW'(1);
         rpt_first <= 1'b1;
      end else if (rpt_fire) begin
         rpt_cnt   <= RW'(1);
         rpt_first <= 1'b0;
      end else begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end

   assign req = (press | rpt_fire) & accept_en;
`else
   assign req = press & accept_en;
`endif

endmodule

module key_move_scheduler #(
   parameter int DEBOUNCE_LEN = 16,
   parameter int GAP_LEN      = 4,
   parameter int REPEAT_DELAY = 1000,
   parameter int REPEAT_RATE  = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_n,
   input  logic       accept_en,
   input  logic       move_ready,
   output logic       move_valid,
   output logic [1:0] move_dir,
   output logic [3:0] pending
);
   localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t        state;
   logic [1:0]    ptr;
   logic [GW-1:0] gap_cnt;
   logic [3:0]    req;
   logic [3:0]    pending_nxt;
   logic          grant_found;
   logic [1:0]    grant_dir;
   logic          grant_take;

   // One front end per key.
   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_LEN (DEBOUNCE_LEN)
`ifdef KEY_REPEAT_EN
         ,
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
`endif
      ) u_key (
         .clk       (clk),
         .reset     (reset),
         .key_raw_n (key_n[k]),
         .accept_en (accept_en),
         .req       (req[k])
      );
   end

   // Round-robin pick: scan ptr, ptr+1, ... with wrap. Walking the offsets
   // from farthest to nearest lets the nearest set bit overwrite the rest.
   always_comb begin
      logic [1:0] idx;
      grant_found = 1'b0;
      grant_dir   = ptr;
      idx         = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (pending[idx]) begin
            grant_found = 1'b1;
            grant_dir   = idx;
         end
      end
   end

   // Requests cleared while accept_en is low are not serviced.
   assign grant_take = (state == IDLE) && accept_en && grant_found;

   // Grant clears first, then a same-cycle press sets the bit again.
   always_comb begin
      pending_nxt = pending;
      if (grant_take) pending_nxt[grant_dir] = 1'b0;
      pending_nxt = pending_nxt | req;
      if (!accept_en) pending_nxt = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pending <= '0;
      else        pending <= pending_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ptr        <= 2'd0;
         gap_cnt    <= '0;
         move_valid <= 1'b0;
         move_dir   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_take) begin
                  move_dir   <= grant_dir;
                  move_valid <= 1'b1;
                  ptr        <= grant_dir + 2'd1;
                  state      <= OFFER;
               end
            end
            // The offer is never withdrawn; accept_en only affects requests.
            OFFER: begin
               if (move_ready) begin
                  move_valid <= 1'b0;
                  gap_cnt    <= '0;
                  state      <= (GAP_LEN > 0) ? GAP : IDLE;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(GAP_LEN - 1)) state <= IDLE;
               else                            gap_cnt <= gap_cnt + 1'b1;
            end
            default: begin
               state      <= IDLE;
               move_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_move_scheduler.sv
// Bench for key_move_scheduler (default build, DEBOUNCE_LEN=16, GAP_LEN=4).
// A cycle-level reference model is compared against the outputs on every
// falling edge; directed scenarios add hand-computed literal checks.
module tb_key_move_scheduler;
   localparam int DL = 16;
   localparam int G  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] key_n = 4'hF;
   logic       accept_en = 1'b1;
   logic       move_ready = 1'b1;
   logic       move_valid;
   logic [1:0] move_dir;
   logic [3:0] pending;

   int n_assert = 0;
   int n_fail   = 0;

   key_move_scheduler #(.DEBOUNCE_LEN(DL), .GAP_LEN(G)) dut (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n),
      .accept_en  (accept_en),
      .move_ready (move_ready),
      .move_valid (move_valid),
      .move_dir   (move_dir),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Debounce as run-length of disagreeing samples seen two edges late;
   // the handshake side tracks the earliest edge number a grant may occur.
   bit   h1 [4];
   bit   h2 [4];
   bit   deb [4];
   int   run [4];
   bit   m_press [4];
   bit   m_valid;
   int   m_dir;
   int   m_ptr;
   bit   m_pend [4];
   int   cyc;
   int   next_ok;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 4; k++) begin
            h1[k] = 0; h2[k] = 0; deb[k] = 0; run[k] = 0;
            m_press[k] = 0; m_pend[k] = 0;
         end
         m_valid = 0; m_dir = 0; m_ptr = 0; cyc = 0; next_ok = 0;
      end else begin
         bit nxt [4];
         bit any;
         int g;
         cyc++;
         any = 0;
         for (int k = 0; k < 4; k++) begin
            nxt[k] = m_pend[k];
            any = any | m_pend[k];
         end
         if (m_valid && move_ready) begin
            m_valid = 0;
            next_ok = cyc + G + 1;
         end else if (!m_valid && cyc >= next_ok && accept_en && any) begin
            g = -1;
            for (int i = 0; i < 4; i++)
               if (g < 0 && m_pend[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
            m_valid = 1;
            m_dir = g;
            m_ptr = (g + 1) % 4;
            nxt[g] = 0;
         end
         for (int k = 0; k < 4; k++) begin
            if (m_press[k]) nxt[k] = 1;
            if (!accept_en) nxt[k] = 0;
            m_pend[k] = nxt[k];
         end
         for (int k = 0; k < 4; k++) begin
            m_press[k] = 0;
            if (h2[k] != deb[k]) begin
               run[k]++;
               if (run[k] == DL) begin
                  m_press[k] = h2[k];
                  deb[k] = h2[k];
                  run[k] = 0;
               end
            end else begin
               run[k] = 0;
            end
            h2[k] = h1[k];
            h1[k] = ~key_n[k];
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         logic [3:0] mp;
         for (int k = 0; k < 4; k++) mp[k] = m_pend[k];
         chk("model_valid", move_valid, m_valid);
         if (m_valid) chk("model_dir", move_dir, m_dir);
         chk("model_pending", pending, mp);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_reset(input logic rdy);
      @(negedge clk);
      key_n = 4'hF;
      accept_en = 1'b1;
      move_ready = rdy;
      reset = 1'b0;
      #2;
      chk("reset_valid", move_valid, 0);
      chk("reset_dir", move_dir, 0);
      chk("reset_pending", pending, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (move_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("wait_valid_timeout", 0, 1);
   endtask

   task automatic count_valid(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (move_valid) cnt++;
      end
   endtask

   initial begin
      bit ok;
      int cnt;
      int seen;

      // 1: single press of left, latency and exactly one move
      do_reset(1'b1);
      key_n = 4'b1011;
      repeat (19) @(posedge clk); #1;
      chk("t1_valid_e19", move_valid, 0);
      chk("t1_pend_e19", pending, 4'b0100);
      @(posedge clk); #1;
      chk("t1_valid_e20", move_valid, 1);
      chk("t1_dir_e20", move_dir, 2);
      chk("t1_pend_e20", pending, 0);
      @(posedge clk); #1;
      chk("t1_taken_e21", move_valid, 0);
      count_valid(60, cnt);
      chk("t1_one_move", cnt, 0);

      // 2: short glitch gives no press
      do_reset(1'b1);
      key_n = 4'b1110;
      repeat (5) @(negedge clk);
      key_n = 4'hF;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (move_valid || pending != 0) seen++;
      end
      chk("t2_glitch_quiet", seen, 0);

      // 3: simultaneous up+right, round-robin from ptr 0
      do_reset(1'b1);
      key_n = 4'b0110;
      repeat (20) @(posedge clk); #1;
      chk("t3_valid_e20", move_valid, 1);
      chk("t3_dir_e20", move_dir, 0);
      chk("t3_pend_e20", pending, 4'b1000);
      @(posedge clk); #1;
      chk("t3_taken_e21", move_valid, 0);
      repeat (4) @(posedge clk); #1;
      chk("t3_gap_e25", move_valid, 0);
      @(posedge clk); #1;
      chk("t3_valid_e26", move_valid, 1);
      chk("t3_dir_e26", move_dir, 3);
      @(posedge clk); #1;
      chk("t3_taken_e27", move_valid, 0);
      @(negedge clk); key_n = 4'hF;
      repeat (40) @(negedge clk);
      key_n = 4'b0110;
      wait_valid(ok);
      chk("t3_ptr_wrapped", move_dir, 0);
      @(negedge clk); key_n = 4'hF;
      repeat (40) @(negedge clk);

      // 4: offer held while the same key is pressed again
      do_reset(1'b0);
      key_n = 4'b1101;
      repeat (20) @(posedge clk); #1;
      chk("t4_valid", move_valid, 1);
      chk("t4_dir", move_dir, 1);
      @(negedge clk); key_n = 4'hF;
      repeat (25) @(negedge clk);
      key_n = 4'b1101;
      repeat (19) @(posedge clk); #1;
      chk("t4_repend", pending, 4'b0010);
      chk("t4_still_valid", move_valid, 1);
      chk("t4_dir_stable", move_dir, 1);
      @(negedge clk); key_n = 4'hF; move_ready = 1'b1;
      @(posedge clk); #1;
      chk("t4_taken", move_valid, 0);
      wait_valid(ok);
      chk("t4_second_dir", move_dir, 1);
      @(posedge clk); #1;
      chk("t4_second_taken", move_valid, 0);

      // 5: accept_en low clears pending, offer still completes
      do_reset(1'b0);
      key_n = 4'b1110;
      repeat (20) @(posedge clk); #1;
      chk("t5_dir", move_dir, 0);
      @(negedge clk); key_n = 4'b0100;
      repeat (19) @(posedge clk); #1;
      chk("t5_pend_1010", pending, 4'b1010);
      @(negedge clk); accept_en = 1'b0;
      @(posedge clk); #1;
      chk("t5_pend_clr", pending, 0);
      chk("t5_offer_kept", move_valid, 1);
      @(negedge clk); key_n = 4'b0000;
      repeat (30) @(posedge clk); #1;
      chk("t5_press_ignored", pending, 0);
      @(negedge clk); move_ready = 1'b1;
      @(posedge clk); #1;
      chk("t5_offer_taken", move_valid, 0);
      count_valid(10, cnt);
      @(negedge clk); accept_en = 1'b1;
      count_valid(30, seen);
      chk("t5_no_more_moves", cnt + seen, 0);

      // 6: reset in the middle of an offer
      do_reset(1'b0);
      key_n = 4'b1101;
      repeat (20) @(posedge clk); #1;
      chk("t6_valid", move_valid, 1);
      @(negedge clk); key_n = 4'b0101;
      repeat (19) @(posedge clk); #1;
      chk("t6_pend", pending, 4'b1000);
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_valid", move_valid, 0);
      chk("t6_rst_pend", pending, 0);
      chk("t6_rst_dir", move_dir, 0);
      key_n = 4'hF;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
